mux16_rr_sequencer: RTL and testbench
=====================================

Name: mux16_rr_sequencer

Overview:
- Round-robin scheduler that shares one 16-to-1 bit multiplexer among 16 requesters.
- Picks one pending requester, drives the 4-bit mux select, and waits a settle interval.
- Samples the mux output, then presents {channel, bit} downstream under a valid/ready handshake.
- Sits between the requester bank and the MUX16to1 datapath; the mux itself stays outside this block.

Parameters:
- SETTLE_CYCLES, 1: cycles between select update and sampling of mux_w; legal range 1..15.

Ports:
- clk        input   1   rising-edge clock
- rst        input   1   synchronous, active-high reset
- req        input   16  per-channel request; bit i held high until ack[i]
- ack        output  16  one-hot, combinational; ack[sel] = valid & out_ready
- sel        output  4   select to the mux; s[3:2] drive the second stage, s[1:0] the first stage
- mux_w      input   1   mux output w
- out_valid  output  1   sample available
- out_ready  input   1   downstream accepts sample
- out_ch     output  4   channel of the presented sample (equals sel)
- out_bit    output  1   sampled mux_w

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE, sel=0, ptr=0, cnt=0, out_valid=0, out_bit=0.
  - ack=0 because it is derived from out_valid.
  - Reset mid-transaction discards it; no ack is issued.
- States: IDLE, SETTLE, PRESENT.
- IDLE:
  - req==0: stay; sel holds its last value.
  - Otherwise the winner is the first set bit scanning ptr, ptr+1, … with wrap 15→0.
  - sel<=winner, cnt<=0, go SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1: out_bit<=mux_w, out_valid<=1, go PRESENT.
  - Net effect: mux_w is sampled after sel has been stable for SETTLE_CYCLES full cycles.
- PRESENT:
  - out_valid, out_ch and out_bit stay stable until out_ready=1.
  - On the out_valid&out_ready cycle: ack[sel]=1 that cycle only, out_valid<=0, ptr<=sel+1 (4-bit wrap, 15→0), go IDLE.
- Latency:
  - First req high in IDLE → out_valid = 1+SETTLE_CYCLES cycles.
  - Minimum period per grant = SETTLE_CYCLES+2 cycles.
- Fairness: a requester still pending when another is acked waits at most 15 grants.
- Requester rules:
  - Drop req[i] the cycle after ack[i].
  - A req still high in a later IDLE cycle counts as a new request.
  - Withdrawing req before ack is illegal; the transaction completes regardless, and sel is never changed outside IDLE.
- Simultaneous events:
  - All 16 requests set: grants follow ptr order.
  - A req arriving during SETTLE or PRESENT is only considered in the next IDLE.
- mux_w changing after the sample point does not affect out_bit.

Optional Feature:
- Macro: MUX16_SEQ_STATS_EN.
- Defined:
  - Adds output grant_cnt[15:0]: count of completed handshakes, wraps 0xFFFF→0.
  - Adds output busy_cnt[15:0]: cycles spent in SETTLE or PRESENT, saturates at 0xFFFF.
  - Both counters clear on rst.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package mux16_seq_pkg:
  - NUM_CH=16, SEL_W=4.
  - typedef enum logic[1:0] {IDLE, SETTLE, PRESENT} seq_state_t.
- One sub-module, rr_pick16:
  - Combinational rotate-and-priority-encode.
  - Inputs: req[15:0], ptr[3:0]. Outputs: any, idx[3:0].
  - Tested standalone with all ptr values.

Test Plan:
- Single request, SETTLE_CYCLES=1: req=16'h0020, mux_w=1, out_ready=1.
  - sel=5 one cycle after req; out_valid two cycles after req with out_ch=5, out_bit=1, ack=16'h0020 that cycle.
  - Back in IDLE next cycle.
- Round-robin order: req=16'hFFFF held (each bit dropped one cycle after its ack, then re-raised).
  - Grants run 0,1,…,15,0 from reset; no channel granted twice within any 16 consecutive grants.
- Wrap and pointer: after a grant to 14, req=16'h4001.
  - Next grant is 0, not 14 (scan 15→0 wins before 14).
- Backpressure: out_ready=0 for 10 cycles while in PRESENT, mux_w toggled meanwhile.
  - out_valid, out_ch and out_bit remain constant; ack=0 throughout; a single ack when out_ready rises.
- Settle timing, SETTLE_CYCLES=3: mux_w model drives the selected J bit only from the third cycle after the sel change, garbage before.
  - out_bit always equals the selected J bit.
- Reset mid-operation: assert rst in SETTLE with sel=9.
  - Next cycle: out_valid=0, sel=0, ack=0; after release, req=16'h0200 is re-granted with full settle latency.
  - With MUX16_SEQ_STATS_EN: grant_cnt=0 after reset.

Source files
------------

// File: rtl/mux16_rr_sequencer_pkg.sv
// mux16_seq_pkg: shared constants and FSM state type for the mux16 round-robin sequencer.
//   NUM_CH : number of requesters (one per mux input)
//   SEL_W  : mux select width
package mux16_seq_pkg;
  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } seq_state_t;
endpackage

// File: rtl/mux16_rr_sequencer_if.sv
// mux16_rr_sequencer_if: requester bank + mux + downstream bundle.
//   master : the sequencer side (drives ack, sel, out_*)
//   slave  : the environment side (drives req, mux_w, out_ready)
interface mux16_rr_sequencer_if;
  import mux16_seq_pkg::*;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ack;
  logic [SEL_W-1:0]  sel;
  logic              mux_w;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_ch;
  logic              out_bit;

  modport master (
    input  req, mux_w, out_ready,
    output ack, sel, out_valid, out_ch, out_bit
  );

  modport slave (
    output req, mux_w, out_ready,
    input  ack, sel, out_valid, out_ch, out_bit
  );
endinterface

// File: rtl/mux16_rr_sequencer_pick.sv
// rr_pick16: combinational round-robin picker.
//   req[15:0] : pending requests
//   ptr[3:0]  : highest-priority channel this round
//   any       : at least one request pending
//   idx[3:0]  : first set bit scanning ptr, ptr+1, ... wrapping 15->0
module rr_pick16
  import mux16_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              any,
  output logic [SEL_W-1:0]  idx
);
  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [SEL_W-1:0]    off;

  // Doubling the vector turns the wrap into a plain slice: rot[k] = req[(ptr+k) mod 16].
  assign dbl = {req, req};
  assign rot = dbl[{1'b0, ptr} +: NUM_CH];

  // Lowest set bit of the rotated vector; scanning downward lets the lowest win.
  always_comb begin
    off = '0;
    for (int k = NUM_CH-1; k >= 0; k--)
      if (rot[k]) off = SEL_W'(k);
  end

  assign any = |req;
  assign idx = ptr + off;
endmodule

// File: rtl/mux16_rr_sequencer.sv
// mux16_rr_sequencer: shares one external 16:1 bit mux among 16 requesters.
// Picks a pending requester round-robin, drives sel, waits SETTLE_CYCLES,
// samples mux_w and presents {out_ch, out_bit} under valid/ready.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : mux16_rr_sequencer_if.master (req/ack, sel/mux_w, out_*)
//   grant_cnt : completed handshakes, wrapping   (only with MUX16_SEQ_STATS_EN)
//   busy_cnt  : cycles in SETTLE/PRESENT, saturating (only with MUX16_SEQ_STATS_EN)
// Parameter SETTLE_CYCLES (1..15): full cycles sel is stable before mux_w is sampled.
module mux16_rr_sequencer
  import mux16_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mux16_rr_sequencer_if.master bus
`ifdef MUX16_SEQ_STATS_EN
  ,
  output logic [15:0]          grant_cnt,
  output logic [15:0]          busy_cnt
`endif
);
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  seq_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel;
  logic [3:0]       cnt;
  logic             out_valid;
  logic             out_bit;
  logic             any;
  logic [SEL_W-1:0] win;
  logic             fire;

  rr_pick16 u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (any),
    .idx (win)
  );

  assign fire = out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else begin
      case (state)
        // sel only moves here, so the mux input is stable for the whole transaction.
        IDLE: if (any) begin
          sel   <= win;
          cnt   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            out_bit   <= bus.mux_w;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: if (bus.out_ready) begin
          out_valid <= 1'b0;
          ptr       <= sel + 4'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack       = fire ? (NUM_CH'(1) << sel) : '0;
  assign bus.sel       = sel;
  assign bus.out_valid = out_valid;
  assign bus.out_ch    = sel;
  assign bus.out_bit   = out_bit;

`ifdef MUX16_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      busy_cnt  <= '0;
    end else begin
      if (fire) grant_cnt <= grant_cnt + 16'd1;
      if (state != IDLE && busy_cnt != 16'hFFFF) busy_cnt <= busy_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mux16_rr_sequencer.sv
`timescale 1ns/1ps
module tb_mux16_rr_sequencer;
  import mux16_seq_pkg::*;

  localparam int SA = 1;
  localparam int SB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  mux16_rr_sequencer_if a();
  mux16_rr_sequencer_if b();

  // Instance A: ideal mux, with an override for toggling mux_w during stalls.
  logic [15:0] aj, bj;
  logic        force_en, force_val;
  assign a.mux_w = force_en ? force_val : aj[a.sel];

  // Instance B: mux output only valid from the 3rd cycle after sel changes.
  logic [3:0] b_prev = '0;
  logic [3:0] b_stab = '0;
  logic [3:0] b_age;
  always @(posedge clk) begin
    b_prev <= b.sel;
    if (b.sel != b_prev) b_stab <= 4'd2;
    else if (b_stab != 4'hF) b_stab <= b_stab + 4'd1;
  end
  assign b_age   = (b.sel != b_prev) ? 4'd1 : b_stab;
  assign b.mux_w = (b_age >= 4'd3) ? bj[b.sel] : ~bj[b.sel];

`ifdef MUX16_SEQ_STATS_EN
  logic [15:0] a_gc, a_bc, b_gc, b_bc;
  mux16_rr_sequencer #(.SETTLE_CYCLES(SA)) dut_a (.clk(clk), .rst(rst), .bus(a.master), .grant_cnt(a_gc), .busy_cnt(a_bc));
  mux16_rr_sequencer #(.SETTLE_CYCLES(SB)) dut_b (.clk(clk), .rst(rst), .bus(b.master), .grant_cnt(b_gc), .busy_cnt(b_bc));
`else
  mux16_rr_sequencer #(.SETTLE_CYCLES(SA)) dut_a (.clk(clk), .rst(rst), .bus(a.master));
  mux16_rr_sequencer #(.SETTLE_CYCLES(SB)) dut_b (.clk(clk), .rst(rst), .bus(b.master));
`endif

  logic [15:0] p_req;
  logic [3:0]  p_ptr, p_idx;
  logic        p_any;
  rr_pick16 u_pick (.req(p_req), .ptr(p_ptr), .any(p_any), .idx(p_idx));

  // Reference: first pending channel in order p, p+1, ... mod 16; -1 if none.
  function automatic int rr_winner(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++)
      if (r[(p + k) % 16]) return (p + k) % 16;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a.req = '0; b.req = '0; a.out_ready = 1'b1; b.out_ready = 1'b1; force_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input bit on_b, input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (on_b ? b.out_valid : a.out_valid) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (a.out_valid !== 1'b0 || a.sel !== 4'd0 || a.ack !== 16'h0 || a.out_bit !== 1'b0)
      begin failures++; $display("FAIL reset_a valid=%b sel=%0d ack=%h bit=%b exp 0/0/0/0", a.out_valid, a.sel, a.ack, a.out_bit); end
    checks++; if (b.out_valid !== 1'b0 || b.sel !== 4'd0 || b.ack !== 16'h0)
      begin failures++; $display("FAIL reset_b valid=%b sel=%0d ack=%h exp 0/0/0", b.out_valid, b.sel, b.ack); end
`ifdef MUX16_SEQ_STATS_EN
    checks++; if (a_gc !== 16'd0 || a_bc !== 16'd0)
      begin failures++; $display("FAIL reset_stats grant=%0d busy=%0d exp 0/0", a_gc, a_bc); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_pick();
    int e;
    for (int p = 0; p < 16; p++)
      for (int t = 0; t < 4; t++) begin
        p_ptr = 4'(p);
        p_req = (t == 0) ? 16'h0 : (t == 1) ? 16'(1 << ((p + 15) % 16)) : 16'($urandom & $urandom);
        #1;
        e = rr_winner(p_req, p);
        checks++;
        if (p_any !== (e >= 0) || (e >= 0 && int'(p_idx) !== e)) begin
          failures++; $display("FAIL pick ptr=%0d req=%h any=%b idx=%0d exp_idx=%0d", p, p_req, p_any, p_idx, e);
        end
      end
  endtask

  task automatic test_single();
    do_reset();
    aj = 16'h0020; a.out_ready = 1'b1; a.req = 16'h0020;
    @(negedge clk);
    checks++; if (a.sel !== 4'd5 || a.out_valid !== 1'b0)
      begin failures++; $display("FAIL single_sel sel=%0d valid=%b exp 5/0", a.sel, a.out_valid); end
    @(negedge clk); #1;
    checks++; if (a.out_valid !== 1'b1 || a.out_ch !== 4'd5 || a.out_bit !== 1'b1)
      begin failures++; $display("FAIL single_out valid=%b ch=%0d bit=%b exp 1/5/1", a.out_valid, a.out_ch, a.out_bit); end
    checks++; if (a.ack !== 16'h0020)
      begin failures++; $display("FAIL single_ack ack=%h exp 0020", a.ack); end
    @(negedge clk); a.req = '0; #1;
    checks++; if (a.out_valid !== 1'b0 || a.ack !== 16'h0)
      begin failures++; $display("FAIL single_idle valid=%b ack=%h exp 0/0000", a.out_valid, a.ack); end
  endtask

  task automatic test_rr_order();
    int lat, ch;
    int hist[17];
    bit dup;
    do_reset();
    aj = 16'($urandom); a.out_ready = 1'b1; a.req = 16'hFFFF;
    for (int g = 0; g < 17; g++) begin
      wait_valid(1'b0, 8, lat);
      ch = int'(a.out_ch);
      checks++; if (lat < 0 || ch !== g % 16 || a.out_bit !== aj[g % 16])
        begin failures++; $display("FAIL rr_order grant=%0d ch=%0d bit=%b lat=%0d exp ch=%0d bit=%b", g, ch, a.out_bit, lat, g % 16, aj[g % 16]); end
      hist[g] = ch; dup = 1'b0;
      for (int k = 1; k < 16 && k <= g; k++) if (hist[g - k] == ch) dup = 1'b1;
      checks++; if (dup) begin failures++; $display("FAIL rr_repeat grant=%0d ch=%0d repeated within 16", g, ch); end
      @(negedge clk); a.req[ch] = 1'b0;
      @(negedge clk); a.req[ch] = 1'b1;
    end
    a.req = '0;
  endtask

  task automatic test_wrap();
    int lat;
    do_reset();
    aj = 16'hFFFF; a.out_ready = 1'b1; a.req = 16'h4000;
    wait_valid(1'b0, 8, lat);
    checks++; if (lat < 0 || a.out_ch !== 4'd14) begin failures++; $display("FAIL wrap_first ch=%0d lat=%0d exp 14", a.out_ch, lat); end
    @(negedge clk); a.req = 16'h4001;
    wait_valid(1'b0, 8, lat);
    checks++; if (lat < 0 || a.out_ch !== 4'd0) begin failures++; $display("FAIL wrap_scan ch=%0d lat=%0d exp 0", a.out_ch, lat); end
    @(negedge clk); a.req = 16'h4000;
    wait_valid(1'b0, 8, lat);
    checks++; if (lat < 0 || a.out_ch !== 4'd14) begin failures++; $display("FAIL wrap_after ch=%0d lat=%0d exp 14", a.out_ch, lat); end
    @(negedge clk); a.req = '0;
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    aj = 16'h0008; a.out_ready = 1'b0; a.req = 16'h0008;
    wait_valid(1'b0, 8, lat);
    checks++; if (lat != SA + 1) begin failures++; $display("FAIL bp_latency lat=%0d exp %0d", lat, SA + 1); end
    force_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      force_val = (i % 2 == 0);
      @(negedge clk);
      checks++; if (a.out_valid !== 1'b1 || a.out_ch !== 4'd3 || a.out_bit !== 1'b1 || a.ack !== 16'h0)
        begin failures++; $display("FAIL bp_stall cyc=%0d valid=%b ch=%0d bit=%b ack=%h exp 1/3/1/0000", i, a.out_valid, a.out_ch, a.out_bit, a.ack); end
    end
    a.out_ready = 1'b1; #1;
    checks++; if (a.ack !== 16'h0008) begin failures++; $display("FAIL bp_ack ack=%h exp 0008", a.ack); end
    @(negedge clk); a.req = '0; #1;
    checks++; if (a.out_valid !== 1'b0 || a.ack !== 16'h0)
      begin failures++; $display("FAIL bp_release valid=%b ack=%h exp 0/0000", a.out_valid, a.ack); end
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    aj = 16'h0200; a.out_ready = 1'b1; a.req = 16'h0200;
    @(negedge clk);
    checks++; if (a.sel !== 4'd9 || a.out_valid !== 1'b0)
      begin failures++; $display("FAIL rstmid_settle sel=%0d valid=%b exp 9/0", a.sel, a.out_valid); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (a.out_valid !== 1'b0 || a.sel !== 4'd0 || a.ack !== 16'h0)
      begin failures++; $display("FAIL rstmid_clear valid=%b sel=%0d ack=%h exp 0/0/0000", a.out_valid, a.sel, a.ack); end
`ifdef MUX16_SEQ_STATS_EN
    checks++; if (a_gc !== 16'd0) begin failures++; $display("FAIL rstmid_grant_cnt got=%0d exp 0", a_gc); end
`endif
    wait_valid(1'b0, 8, lat);
    checks++; if (lat != SA + 1 || a.out_ch !== 4'd9 || a.out_bit !== 1'b1)
      begin failures++; $display("FAIL rstmid_regrant lat=%0d ch=%0d bit=%b exp %0d/9/1", lat, a.out_ch, a.out_bit, SA + 1); end
    @(negedge clk); a.req = '0;
  endtask

  task automatic test_random();
    logic [15:0] rq, exp_ack;
    int mptr, exp, lat, hs;
    bit seen, upd;
    do_reset();
    mptr = 0; rq = 16'($urandom) | 16'(1 << $urandom_range(0, 15));
    a.req = rq; aj = 16'($urandom); exp = rr_winner(rq, mptr);
    lat = 0; seen = 1'b0; upd = 1'b0; hs = 0;
    for (int cyc = 0; cyc < 3000 && hs < 150; cyc++) begin
      @(negedge clk);
      if (upd) begin
        rq[exp] = 1'b0;
        rq |= 16'($urandom & $urandom & $urandom);
        if (rq == 16'h0) rq[$urandom_range(0, 15)] = 1'b1;
        a.req = rq; aj = 16'($urandom);
        mptr = (exp + 1) % 16; exp = rr_winner(rq, mptr);
        lat = 0; seen = 1'b0; upd = 1'b0;
      end else lat++;
      if (a.out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          checks++; if (lat != SA + 1) begin failures++; $display("FAIL rand_latency lat=%0d exp %0d", lat, SA + 1); end
        end
        checks++; if (int'(a.out_ch) !== exp || a.out_bit !== aj[exp])
          begin failures++; $display("FAIL rand_out ch=%0d bit=%b exp ch=%0d bit=%b req=%h", a.out_ch, a.out_bit, exp, aj[exp], rq); end
      end else if (lat == SA + 8) begin
        checks++; failures++; $display("FAIL rand_timeout no out_valid after %0d cycles exp %0d", lat, SA + 1);
      end
      a.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_ack = (a.out_valid && a.out_ready) ? 16'(1 << exp) : 16'h0;
      checks++; if (a.ack !== exp_ack) begin failures++; $display("FAIL rand_ack ack=%h exp %h", a.ack, exp_ack); end
      if (a.out_valid && a.out_ready) begin upd = 1'b1; hs++; end
    end
    @(negedge clk); a.out_ready = 1'b0;
`ifdef MUX16_SEQ_STATS_EN
    checks++; if (int'(a_gc) !== hs) begin failures++; $display("FAIL rand_grant_cnt got=%0d exp %0d", a_gc, hs); end
`endif
    a.req = '0;
  endtask

  task automatic test_settle3();
    int lat, ch;
    do_reset();
    b.out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      ch = $urandom_range(0, 15); bj = 16'($urandom); b.req = 16'(1 << ch);
      wait_valid(1'b1, 12, lat);
      checks++; if (lat != SB + 1) begin failures++; $display("FAIL settle3_latency lat=%0d exp %0d", lat, SB + 1); end
      checks++; if (int'(b.out_ch) !== ch || b.out_bit !== bj[ch])
        begin failures++; $display("FAIL settle3_out ch=%0d bit=%b exp ch=%0d bit=%b", b.out_ch, b.out_bit, ch, bj[ch]); end
      #1;
      checks++; if (b.ack !== 16'(1 << ch)) begin failures++; $display("FAIL settle3_ack ack=%h exp %h", b.ack, 16'(1 << ch)); end
      @(negedge clk); b.req = '0;
    end
  endtask

  initial begin
    rst = 1'b1; a.req = '0; b.req = '0; a.out_ready = 1'b0; b.out_ready = 1'b0;
    aj = '0; bj = '0; force_en = 1'b0; force_val = 1'b0; p_req = '0; p_ptr = '0;
    test_reset();
    test_pick();
    test_single();
    test_rr_order();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_settle3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
